// File: rtl/cpu_pkg.sv
// Shared types for the execution stage: ALU op encoding, FSM states and datapath sizes.
package cpu_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    // {funct7[5], funct3}; unlisted codes execute as ADD
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_state_t;

    function automatic logic is_shift_op(alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Pure combinational RV32I integer function f(A,B,op).
// Shift ops pass A through unless OPERAND_ALU_BARREL_SHIFT_EN selects a barrel shifter.
module alu_comb
    import cpu_pkg::*;
#(
    parameter int WIDTH   = cpu_pkg::WIDTH,
    parameter int SHAMT_W = cpu_pkg::SHAMT_W
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_t          op_i,
    output logic [WIDTH-1:0] y_o
);

`ifdef OPERAND_ALU_BARREL_SHIFT_EN
    logic [SHAMT_W-1:0] shamt;
    assign shamt = b_i[SHAMT_W-1:0];
`endif

    always_comb begin
        y_o = a_i + b_i;
        case (op_i)
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLT:  y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: y_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
`ifdef OPERAND_ALU_BARREL_SHIFT_EN
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
`else
            // The serial shifter starts from A and works on R over several cycles
            ALU_SLL, ALU_SRL, ALU_SRA: y_o = a_i;
`endif
            default:  y_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/operand_alu.sv
// Execution stage: A/B operand latches, result register R, bit-serial shifter and bus/addr drivers.
// Define OPERAND_ALU_BARREL_SHIFT_EN for single-cycle shifts (busy tied low, no SHIFT state).
module operand_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH   = cpu_pkg::WIDTH,
    parameter int SHAMT_W = cpu_pkg::SHAMT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    inout  wire  [WIDTH-1:0] bus,
    inout  wire  [WIDTH-1:0] addr,
    input  logic             a_write,
    input  logic             b_write,
    input  logic             a_bus,
    input  logic             b_bus,
    input  logic             alu_bus,
    input  logic             a_addr,
    input  logic             b_addr,
    input  logic             alu_addr,
    input  logic [3:0]       alu_op,
    input  logic             alu_start,
    output logic             busy,
    output alu_state_t       dbg_state_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] alu_y;
    alu_op_t          op_in;

    assign op_in = alu_op_t'(alu_op);

    alu_comb #(
        .WIDTH  (WIDTH),
        .SHAMT_W(SHAMT_W)
    ) u_alu_comb (
        .a_i (a_q),
        .b_i (b_q),
        .op_i(op_in),
        .y_o (alu_y)
    );

    // Captures happen regardless of busy; the shift only ever touches R
    assign a_d = a_write ? bus : a_q;
    assign b_d = b_write ? bus : b_q;

`ifndef OPERAND_ALU_BARREL_SHIFT_EN
    logic [SHAMT_W-1:0] count_q, count_d;
    alu_op_t            op_q, op_d;
    alu_state_t         state_q, state_d;
    logic [WIDTH-1:0]   shift_step;

    assign shift_step = (op_q == ALU_SLL) ? {r_q[WIDTH-2:0], 1'b0}
                                          : {(op_q == ALU_SRA) & r_q[WIDTH-1], r_q[WIDTH-1:1]};

    always_comb begin
        r_d     = r_q;
        count_d = count_q;
        op_d    = op_q;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (alu_start) begin
                    if (is_shift_op(op_in)) begin
                        r_d     = a_q;
                        count_d = b_q[SHAMT_W-1:0];
                        op_d    = op_in;
                        if (b_q[SHAMT_W-1:0] != '0) state_d = SHIFT;
                    end else begin
                        r_d = alu_y;
                    end
                end
            end
            SHIFT: begin
                // alu_start is ignored here; the shift always runs to completion
                r_d     = shift_step;
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            op_q    <= ALU_ADD;
            state_q <= IDLE;
        end else begin
            count_q <= count_d;
            op_q    <= op_d;
            state_q <= state_d;
        end
    end

    assign busy        = (state_q == SHIFT);
    assign dbg_state_o = state_q;
`else
    assign r_d         = alu_start ? alu_y : r_q;
    assign busy        = 1'b0;
    assign dbg_state_o = IDLE;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
        end
    end

    // Fixed priority R > A > B on both shared buses
    assign bus  = alu_bus  ? r_q : a_bus  ? a_q : b_bus  ? b_q : {WIDTH{1'bz}};
    assign addr = alu_addr ? r_q : a_addr ? a_q : b_addr ? b_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_operand_alu.sv
// Self-checking bench for operand_alu: vector table through a result scoreboard plus multi-cycle sequences.
module tb_operand_alu;
    import cpu_pkg::*;

`ifdef OPERAND_ALU_BARREL_SHIFT_EN
    localparam int SERIAL = 0;
`else
    localparam int SERIAL = 1;
`endif

    logic        clk;
    logic        reset_n;
    wire  [31:0] bus;
    wire  [31:0] addr;
    logic        a_write, b_write;
    logic        a_bus, b_bus, alu_bus;
    logic        a_addr, b_addr, alu_addr;
    logic [3:0]  alu_op;
    logic        alu_start;
    logic        busy;
    alu_state_t  dbg_state;

    logic        tb_en;
    logic [31:0] tb_val;

    // Released buses float high so a released bus reads as all ones
    assign bus = tb_en ? tb_val : 32'hzzzz_zzzz;
    pullup (bus);
    pullup (addr);

    operand_alu dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .addr       (addr),
        .a_write    (a_write),
        .b_write    (b_write),
        .a_bus      (a_bus),
        .b_bus      (b_bus),
        .alu_bus    (alu_bus),
        .a_addr     (a_addr),
        .b_addr     (b_addr),
        .alu_addr   (alu_addr),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          busy_cyc;
        string       name;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [31:0] v);
        tb_en = 1'b1; tb_val = v; a_write = 1'b1;
        step();
        tb_en = 1'b0; a_write = 1'b0;
    endtask

    task automatic write_b(input logic [31:0] v);
        tb_en = 1'b1; tb_val = v; b_write = 1'b1;
        step();
        tb_en = 1'b0; b_write = 1'b0;
    endtask

    task automatic start(input logic [3:0] op);
        alu_op = op; alu_start = 1'b1;
        step();
        alu_start = 1'b0;
    endtask

    task automatic peek_bus(input logic ab, input logic bb, input logic rb, output logic [31:0] v);
        a_bus = ab; b_bus = bb; alu_bus = rb;
        #1;
        v = bus;
        a_bus = 1'b0; b_bus = 1'b0; alu_bus = 1'b0;
        step();
    endtask

    task automatic peek_addr(input logic ab, input logic bb, input logic rb, output logic [31:0] v);
        a_addr = ab; b_addr = bb; alu_addr = rb;
        #1;
        v = addr;
        a_addr = 1'b0; b_addr = 1'b0; alu_addr = 1'b0;
        step();
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            step();
        end
    endtask

    task automatic check_result(input string name);
        logic [31:0] got;
        logic [31:0] exp;
        peek_bus(1'b0, 1'b0, 1'b1, got);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got=%h expected=<empty scoreboard>", name, got);
        end else begin
            exp = exp_q.pop_front();
            chk(name, got, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        int cyc;
        write_a(v.a);
        write_b(v.b);
        exp_q.push_back(v.exp);
        start(v.op);
        wait_done(cyc);
        chk({v.name, "_busy_cycles"}, 32'(cyc), 32'(v.busy_cyc));
        check_result(v.name);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] ra, rb;
        int          cyc;

        reset_n = 1'b0;
        tb_en = 1'b0; tb_val = '0;
        a_write = 1'b0; b_write = 1'b0;
        a_bus = 1'b0; b_bus = 1'b0; alu_bus = 1'b0;
        a_addr = 1'b0; b_addr = 1'b0; alu_addr = 1'b0;
        alu_op = 4'h0; alu_start = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();

        // Reset state and released buses
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_bus_released", bus, 32'hFFFF_FFFF);
        chk("reset_addr_released", addr, 32'hFFFF_FFFF);
        peek_bus(1'b1, 1'b0, 1'b0, v);  chk("reset_a", v, 32'h0);
        peek_bus(1'b0, 1'b1, 1'b0, v);  chk("reset_b", v, 32'h0);
        peek_bus(1'b0, 1'b0, 1'b1, v);  chk("reset_r", v, 32'h0);

        vecs[0]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 0,          "add_wrap"};
        vecs[1]  = '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0,          "sub_wrap"};
        vecs[2]  = '{ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 0,          "slt_neg"};
        vecs[3]  = '{ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 0,          "sltu_big"};
        vecs[4]  = '{ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 0,          "slt_pos_vs_m1"};
        vecs[5]  = '{ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 0,          "sltu_small"};
        vecs[6]  = '{ALU_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 0,          "xor"};
        vecs[7]  = '{ALU_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0,          "or"};
        vecs[8]  = '{ALU_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0,          "and"};
        vecs[9]  = '{ALU_SLL,  32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 4 * SERIAL, "sll_4"};
        vecs[10] = '{ALU_SRL,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1 * SERIAL, "srl_1_upper_b_ignored"};
        vecs[11] = '{ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4 * SERIAL, "sra_4"};
        vecs[12] = '{ALU_SRA,  32'h4000_0000, 32'h0000_0002, 32'h1000_0000, 2 * SERIAL, "sra_pos"};
        vecs[13] = '{4'b1111,  32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 0,          "unknown_op_add"};
        vecs[14] = '{ALU_SLL,  32'h0000_ABCD, 32'h0000_0020, 32'h0000_ABCD, 0,          "sll_shamt0"};

        for (int i = 0; i < 15; i++) apply_vec(vecs[i]);

        // Random arithmetic/logic against a small reference model
        for (int i = 0; i < 6; i++) begin
            vec_t r;
            int   k;
            r.a = $urandom;
            r.b = $urandom;
            k = $urandom_range(0, 2);
            r.busy_cyc = 0;
            case (k)
                0:       begin r.op = ALU_ADD; r.exp = r.a + r.b; r.name = "rand_add"; end
                1:       begin r.op = ALU_SUB; r.exp = r.a - r.b; r.name = "rand_sub"; end
                default: begin r.op = ALU_XOR; r.exp = r.a ^ r.b; r.name = "rand_xor"; end
            endcase
            apply_vec(r);
        end

        // Full-width serial SRA with an ignored restart and an A write while busy
        write_a(32'h8000_0000);
        write_b(32'h0000_001F);
        exp_q.push_back(32'hFFFF_FFFF);
        start(ALU_SRA);
        cyc = 0;
        while (busy && cyc < 100) begin
            if (cyc == 5) begin alu_op = ALU_ADD; alu_start = 1'b1; end
            if (cyc == 10) begin tb_en = 1'b1; tb_val = 32'h0000_1234; a_write = 1'b1; end
            cyc++;
            step();
            alu_start = 1'b0; a_write = 1'b0; tb_en = 1'b0;
        end
        chk("sra31_busy_cycles", 32'(cyc), 32'(31 * SERIAL));
        check_result("sra31_result");
        peek_bus(1'b1, 1'b0, 1'b0, v);
        chk("sra31_a_written_while_busy", v, SERIAL ? 32'h0000_1234 : 32'h8000_0000);

        // Operand write on the same edge as alu_start affects only the next op
        write_a(32'h1);
        write_b(32'h1);
        exp_q.push_back(32'h2);
        tb_en = 1'b1; tb_val = 32'h5; a_write = 1'b1;
        alu_op = ALU_ADD; alu_start = 1'b1;
        step();
        tb_en = 1'b0; a_write = 1'b0; alu_start = 1'b0;
        check_result("same_edge_add");
        peek_bus(1'b1, 1'b0, 1'b0, v);
        chk("same_edge_a_captured", v, 32'h5);

        // Drive priority: R currently 2, A=5, B=1
        peek_bus(1'b1, 1'b1, 1'b1, v);   chk("bus_prio_r", v, 32'h2);
        peek_bus(1'b1, 1'b1, 1'b0, v);   chk("bus_prio_a", v, 32'h5);
        peek_addr(1'b1, 1'b1, 1'b0, v);  chk("addr_prio_a", v, 32'h5);
        peek_addr(1'b0, 1'b1, 1'b0, v);  chk("addr_b", v, 32'h1);
        peek_addr(1'b1, 1'b0, 1'b1, v);  chk("addr_prio_r", v, 32'h2);

        // Asynchronous reset in the middle of a shift
        write_a(32'hFFFF_0000);
        write_b(32'h0000_0014);
        start(ALU_SRL);
        repeat (3) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midshift_reset_busy", {31'b0, busy}, 32'h0);
        chk("midshift_reset_bus_released", bus, 32'hFFFF_FFFF);
        alu_bus = 1'b1;
        #1;
        chk("midshift_reset_r_async", bus, 32'h0);
        alu_bus = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("post_reset_busy", {31'b0, busy}, 32'h0);
        chk("post_reset_addr_released", addr, 32'hFFFF_FFFF);
        peek_bus(1'b1, 1'b0, 1'b0, ra);  chk("post_reset_a", ra, 32'h0);
        peek_bus(1'b0, 1'b1, 1'b0, rb);  chk("post_reset_b", rb, 32'h0);
        peek_bus(1'b0, 1'b0, 1'b1, v);   chk("post_reset_r", v, 32'h0);
        repeat (25) step();
        chk("post_reset_no_late_busy", {31'b0, busy}, 32'h0);
        peek_bus(1'b0, 1'b0, 1'b1, v);   chk("post_reset_r_stable", v, 32'h0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_alu.md
Name: operand_alu

Overview:
- Execution stage directly downstream of the sequencer. It consumes the sequencer's a_*/b_*/alu_* strobes.
- Holds the A and B operand latches loaded from the shared bus, computes RV32I integer results into a result register R, and drives R or an operand onto bus/addr on request.
- Shifts are bit-serial (one bit per clock) to match the TTL cost model. busy tells the sequencer to hold its OP state.

Parameters:
- WIDTH, 32, datapath width of bus, addr, A, B, R.
- SHAMT_W, 5, width of the shift amount, taken from B[SHAMT_W-1:0].

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- bus  inout  WIDTH  shared data bus; driven only as specified, else 'z.
- addr  inout  WIDTH  shared address bus; driven only as specified, else 'z.
- a_write  input  1  capture bus into A at posedge.
- b_write  input  1  capture bus into B at posedge.
- a_bus, b_bus, alu_bus  input  1 each  drive A / B / R onto bus (combinational).
- a_addr, b_addr, alu_addr  input  1 each  drive A / B / R onto addr (combinational).
- alu_op  input  4  operation code, alu_op_t.
- alu_start  input  1  begin operation on the current A, B, alu_op.
- busy  output  1  serial shift in progress.

Behaviour:
- Reset (reset_n low, async): A=0, B=0, R=0, count=0, busy=0, op register=ADD; bus and addr released to 'z immediately.
- alu_op encoding {funct7[5],funct3}:
  - ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100
  - SRL=0101, SRA=1101, OR=0110, AND=0111
  - any other code executes as ADD.
- Bus drive: bus = R if alu_bus, else A if a_bus, else B if b_bus, else 'z. Fixed priority alu > a > b.
- Addr drive: same priority using alu_addr/a_addr/b_addr.
- Operand capture: a_write/b_write capture bus at posedge, independent of busy.
- alu_start sampling: operands are sampled at the same edge as alu_start, using the values held before that edge. A write in the same cycle as alu_start affects the next operation only.
- FSM states: IDLE, SHIFT.
- IDLE, alu_start, non-shift op:
  - R <= f(A,B) at that edge; stay IDLE; result readable the next cycle (latency 1).
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is a signed compare, SLTU unsigned; result 0 or 1, zero-extended.
- IDLE, alu_start, shift op (SLL/SRL/SRA):
  - R <= A, count <= B[SHAMT_W-1:0], op register <= alu_op.
  - If count==0, stay IDLE: result = A, latency 1, busy never rises.
  - Otherwise go to SHIFT with busy=1 from the next cycle.
- SHIFT state:
  - Each posedge: R shifted one bit (SLL zero-fill, SRL zero-fill, SRA sign-fill from R[WIDTH-1]); count decrements.
  - Leave to IDLE on the edge where count goes 1->0.
  - busy is high for exactly shamt cycles; the result is readable the cycle after busy falls. Total latency shamt+1.
- alu_start while busy: ignored; no restart, no error.
- alu_bus/alu_addr while busy: drives the partial R. Undefined for software, but not X.
- Shifting works on R only, so A/B writes during SHIFT do not disturb the shift in progress.
- Reset mid-shift: aborts immediately to IDLE with reset values.

Optional Feature:
- Macro: OPERAND_ALU_BARREL_SHIFT_EN.
- Defined: shifts complete combinationally like other ops, with latency 1. busy is tied 0 and the SHIFT state is not compiled.
- Undefined: serial shifter as above.
- All non-shift behaviour is identical in both builds.

Decomposition:
- Shared package cpu_pkg:
  - alu_op_t enum with the encodings above
  - WIDTH default constant
  - alu_state_t {IDLE, SHIFT}
- Sub-module alu_comb: pure combinational f(A,B,alu_op) for all ops. It contains the barrel shift only when the macro is defined.
- operand_alu owns the latches, the FSM, the serial shifter and the tristate drivers.

Test Plan:
- Reset/tristate: assert reset_n=0 mid-shift; release -> A=B=R=0, busy=0, bus=addr='z with no strobes.
- ADD/SUB: a_write 0xFFFFFFFF, b_write 0x00000002, start ADD -> next cycle alu_bus reads 0x00000001. Start SUB with A=0, B=1 -> 0xFFFFFFFF.
- SLT/SLTU: A=0x80000000, B=0x00000001 -> SLT gives 1, SLTU gives 0.
- Serial SRA: A=0x80000000, B=0x0000001F, start SRA -> busy high exactly 31 cycles, then R=0xFFFFFFFF. alu_start pulsed during busy is ignored, and a_write during busy leaves R unaffected.
- Shift zero / same-edge write: B=0x20 (shamt 0), SLL -> busy stays 0, R=A. a_write 0x5 coincident with alu_start ADD (old A=1, B=1) -> R=2, A=5.
- Drive priority: a_bus=b_bus=alu_bus=1 -> bus=R. a_addr=b_addr=1 -> addr=A.
